// File: rtl/control_modos.sv
// Mode controller and timekeeper for a 24-hour HH:MM clock with one alarm.
// Switches and buttons are synchronized; the 7-segment digits and the alarm LED are registered.
module control_modos #(
  parameter int TICKS_PER_SEC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       incrementar,
  input  logic       decrementar,
  input  logic       cambiar,
  input  logic       establecer,
  output logic [6:0] displayH2,
  output logic [6:0] displayH1,
  output logic [6:0] displayM2,
  output logic [6:0] displayM1,
  output logic       led
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_t;

  typedef enum logic {
    FIELD_HOURS   = 1'b0,
    FIELD_MINUTES = 1'b1
  } field_t;

  function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
    if (up) return (h == 5'd23) ? 5'd0 : h + 5'd1;
    return (h == 5'd0) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] min_step(input logic [5:0] m, input logic up);
    if (up) return (m == 6'd59) ? 6'd0 : m + 6'd1;
    return (m == 6'd0) ? 6'd59 : m - 6'd1;
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [6:0] raw_in, sync1, sync2;
  logic [3:0] btn_prev, press;
  logic       inc_p, dec_p, cam_p, est_p;
  logic       sw1, sw2, sw3;

  mode_t      mode, mode_d;
  field_t     field, field_d;
  logic [4:0] hours, alarm_h, edit_h, edit_h_d;
  logic [5:0] minutes, seconds, alarm_m, edit_m, edit_m_d;
  logic [PW-1:0] presc;
  logic       edit_active, time_commit, alarm_commit;
  logic [4:0] src_h;
  logic [5:0] src_m;

  assign raw_in = {switch3, switch2, switch1, establecer, cambiar, decrementar, incrementar};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      btn_prev <= '0;
    end else begin
      sync1    <= raw_in;
      sync2    <= sync1;
      btn_prev <= sync2[3:0];
    end
  end

  // A press is the synchronized high-to-low transition; holding gives one pulse.
  assign press = btn_prev & ~sync2[3:0];
  assign inc_p = press[0];
  assign dec_p = press[1];
  assign cam_p = press[2];
  assign est_p = press[3];
  assign sw1   = sync2[4];
  assign sw2   = sync2[5];
  assign sw3   = sync2[6];

  always_comb begin
    mode_d = MODE_NORMAL;
    if (sw1)      mode_d = MODE_SET_TIME;
    else if (sw2) mode_d = MODE_SET_ALARM;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mode <= MODE_NORMAL;
    else        mode <= mode_d;
  end

  // Buttons act only while settled in an edit mode, never on the entry/exit cycle.
  assign edit_active  = (mode_d == mode) && (mode != MODE_NORMAL);
  assign time_commit  = edit_active && (mode == MODE_SET_TIME) && est_p;
  assign alarm_commit = edit_active && (mode == MODE_SET_ALARM) && est_p;

  always_comb begin
    edit_h_d = edit_h;
    edit_m_d = edit_m;
    field_d  = field;
    if (mode_d == MODE_SET_TIME && mode != MODE_SET_TIME) begin
      edit_h_d = hours;
      edit_m_d = minutes;
      field_d  = FIELD_HOURS;
    end else if (mode_d == MODE_SET_ALARM && mode != MODE_SET_ALARM) begin
      edit_h_d = alarm_h;
      edit_m_d = alarm_m;
      field_d  = FIELD_HOURS;
    end else if (edit_active) begin
      if (cam_p) field_d = (field == FIELD_HOURS) ? FIELD_MINUTES : FIELD_HOURS;
      if (inc_p != dec_p) begin
        if (field == FIELD_HOURS) edit_h_d = hour_step(edit_h, inc_p);
        else                      edit_m_d = min_step(edit_m, inc_p);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edit_h <= '0;
      edit_m <= '0;
      field  <= FIELD_HOURS;
    end else begin
      edit_h <= edit_h_d;
      edit_m <= edit_m_d;
      field  <= field_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      seconds <= '0;
      minutes <= '0;
      hours   <= '0;
    end else if (time_commit) begin
      presc   <= '0;
      seconds <= '0;
      minutes <= edit_m;
      hours   <= edit_h;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      if (seconds == 6'd59) begin
        seconds <= '0;
        if (minutes == 6'd59) begin
          minutes <= '0;
          hours   <= hour_step(hours, 1'b1);
        end else begin
          minutes <= minutes + 6'd1;
        end
      end else begin
        seconds <= seconds + 6'd1;
      end
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_h <= '0;
      alarm_m <= '0;
    end else if (alarm_commit) begin
      alarm_h <= edit_h;
      alarm_m <= edit_m;
    end
  end

  assign src_h = (mode == MODE_NORMAL) ? hours   : edit_h;
  assign src_m = (mode == MODE_NORMAL) ? minutes : edit_m;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      displayH2 <= SEG_ZERO;
      displayH1 <= SEG_ZERO;
      displayM2 <= SEG_ZERO;
      displayM1 <= SEG_ZERO;
      led       <= 1'b0;
    end else begin
      displayH2 <= seg7(4'(src_h / 5'd10));
      displayH1 <= seg7(4'(src_h % 5'd10));
      displayM2 <= seg7(4'(src_m / 6'd10));
      displayM1 <= seg7(4'(src_m % 6'd10));
      led       <= sw3 && (hours == alarm_h) && (minutes == alarm_m);
    end
  end

endmodule

// File: tb/tb_control_modos.sv
// Directed bench for control_modos: timekeeping, set-time/set-alarm editing, wraps,
// edit discard, alarm LED timing and asynchronous reset mid-edit.
module tb_control_modos;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;

  localparam logic [3:0] B_INC = 4'b0001;
  localparam logic [3:0] B_DEC = 4'b0010;
  localparam logic [3:0] B_CAM = 4'b0100;
  localparam logic [3:0] B_EST = 4'b1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       switch1 = 1'b0, switch2 = 1'b0, switch3 = 1'b0;
  logic       incrementar = 1'b1, decrementar = 1'b1, cambiar = 1'b1, establecer = 1'b1;
  logic [6:0] displayH2, displayH1, displayM2, displayM1;
  logic       led;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  int fall;

  control_modos #(.TICKS_PER_SEC(2)) dut (
    .clk(clk), .reset(reset),
    .switch1(switch1), .switch2(switch2), .switch3(switch3),
    .incrementar(incrementar), .decrementar(decrementar),
    .cambiar(cambiar), .establecer(establecer),
    .displayH2(displayH2), .displayH1(displayH1),
    .displayM2(displayM2), .displayM1(displayM1),
    .led(led)
  );

  // Clock and a count of rising edges since reset release.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
  endtask

  // mask order {establecer, cambiar, decrementar, incrementar}; action lands 3 edges after the fall.
  task automatic press(input logic [3:0] mask);
    {establecer, cambiar, decrementar, incrementar} = ~mask;
    cycles(4);
    {establecer, cambiar, decrementar, incrementar} = 4'hF;
    cycles(3);
  endtask

  task automatic check7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_led(input string tag, input logic exp);
    tests++;
    assert (led === exp) else begin
      fails++;
      $error("FAIL %s: led got %b expected %b", tag, led, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [6:0] h2, input logic [6:0] h1,
                            input logic [6:0] m2, input logic [6:0] m1);
    check7({tag, ".H2"}, displayH2, h2);
    check7({tag, ".H1"}, displayH1, h1);
    check7({tag, ".M2"}, displayM2, m2);
    check7({tag, ".M1"}, displayM1, m1);
  endtask

  initial begin
    // Reset state and the first minute carry.
    do_reset();
    check_disp("reset", S0, S0, S0, S0);
    check_led("reset_led", 1'b0);
    wait_until(120);
    check7("pre_min.M1", displayM1, S0);
    wait_until(121);
    check7("min1.M1", displayM1, S1);

    // Set time to 13:59 and watch it roll to 14:00.
    do_reset();
    switch1 = 1'b1;
    cycles(4);
    check_disp("st_enter", S0, S0, S0, S0);
    repeat (13) press(B_INC);
    check_disp("st_h13", S1, S3, S0, S0);
    press(B_CAM);
    press(B_DEC);
    check_disp("st_1359", S1, S3, S5, S9);
    fall = edge_cnt;
    press(B_EST);
    check_disp("st_commit", S1, S3, S5, S9);
    switch1 = 1'b0;
    cycles(4);
    check_disp("norm_1359", S1, S3, S5, S9);
    wait_until(fall + 123);
    check_disp("pre_1400", S1, S3, S5, S9);
    wait_until(fall + 124);
    check_disp("t_1400", S1, S4, S0, S0);

    // Field wraps, simultaneous inc/dec, edit discard, buttons in NORMAL.
    do_reset();
    switch1 = 1'b1;
    cycles(4);
    press(B_DEC);
    check_disp("wrap_h23", S2, S3, S0, S0);
    press(B_CAM);
    press(B_DEC);
    check_disp("wrap_m59", S2, S3, S5, S9);
    press(B_INC);
    check_disp("wrap_m00", S2, S3, S0, S0);
    press(B_CAM);
    press(B_INC);
    check_disp("wrap_h00", S0, S0, S0, S0);
    press(B_INC | B_DEC);
    check_disp("inc_dec_both", S0, S0, S0, S0);
    repeat (3) press(B_INC);
    check_disp("edit_03", S0, S3, S0, S0);
    switch1 = 1'b0;
    cycles(4);
    check_disp("discard", S0, S0, S0, S0);
    press(B_INC);
    check_disp("normal_btn", S0, S0, S0, S0);
    wait_until(121);
    check_disp("discard_counting", S0, S0, S0, S1);

    // Alarm at 00:02 with switch3 on; clear and restore switch3 inside the match window.
    do_reset();
    switch2 = 1'b1;
    cycles(4);
    press(B_CAM);
    press(B_INC);
    press(B_INC);
    check_disp("alarm_edit", S0, S0, S0, S2);
    press(B_EST);
    switch2 = 1'b0;
    cycles(4);
    check_disp("alarm_norm", S0, S0, S0, S0);
    switch3 = 1'b1;
    cycles(4);
    check_led("led_early", 1'b0);
    wait_until(240);
    check_led("led_pre", 1'b0);
    wait_until(241);
    check_led("led_rise", 1'b1);
    wait_until(300);
    switch3 = 1'b0;
    wait_until(302);
    check_led("led_sw3_lag", 1'b1);
    wait_until(303);
    check_led("led_sw3_off", 1'b0);
    switch3 = 1'b1;
    wait_until(305);
    check_led("led_sw3_relag", 1'b0);
    wait_until(306);
    check_led("led_sw3_on", 1'b1);
    wait_until(360);
    check_led("led_hold", 1'b1);
    wait_until(361);
    check_led("led_fall", 1'b0);

    // Same alarm with switch3 off: LED stays dark.
    switch3 = 1'b0;
    do_reset();
    switch2 = 1'b1;
    cycles(4);
    press(B_CAM);
    press(B_INC);
    press(B_INC);
    press(B_EST);
    switch2 = 1'b0;
    wait_until(245);
    check_disp("noalarm_time", S0, S0, S0, S2);
    check_led("led_disabled", 1'b0);

    // Reset asserted mid-edit in set-alarm after committing 01:00.
    do_reset();
    switch2 = 1'b1;
    cycles(4);
    press(B_INC);
    press(B_EST);
    press(B_INC);
    check_disp("pre_rst_edit", S0, S2, S0, S0);
    switch3 = 1'b1;
    cycles(4);
    check_led("pre_rst_led", 1'b0);
    reset = 1'b0;
    #1;
    check_disp("rst_async", S0, S0, S0, S0);
    check_led("rst_async_led", 1'b0);
    cycles(2);
    reset = 1'b1;
    cycles(4);
    check_disp("rst_alarm_cleared", S0, S0, S0, S0);
    check_led("rst_alarm_match", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
